// File: rtl/io_ir_rx_pkg.sv
// io_ir_rx_pkg: IR protocol profile, bus address map and receiver FSM encoding
package io_ir_rx_pkg;
  localparam logic [7:0] IR_TX_ADDR = 8'h90;
  localparam logic [7:0] IR_RX_ADDR = 8'h91;
  localparam int IR_FULL_PERIOD = 2778;
  localparam int IR_HALF_PERIOD = 1389;
  localparam int IR_TOL = 4;
  typedef struct packed {
    logic [7:0] start;
    logic [7:0] carsel;
    logic [7:0] gap;
    logic [7:0] assert_w;
    logic [7:0] deassert_w;
  } ir_prof_t;
  localparam ir_prof_t IR_BLUE = '{start: 8'd191, carsel: 8'd47, gap: 8'd25, assert_w: 8'd47, deassert_w: 8'd22};
  typedef enum logic [2:0] {S_IDLE, S_START, S_GAP1, S_CARSEL, S_GAP2, S_MARK, S_SPACE} ir_state_t;
  function automatic logic in_win(input logic [7:0] w, input int sz, input int tol);
    return int'(w) >= sz - tol && int'(w) <= sz + tol;
  endfunction
endpackage

// File: rtl/io_ir_rx_pulse_meter.sv
// ir_pulse_meter: synchronises IR envelope, flags edges and measures time since last edge in carrier ticks
module ir_pulse_meter #(
  parameter int TICK_DIV = 2778
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       ir_in,
  output logic       rise,
  output logic       fall,
  output logic [7:0] width
);
  localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [2:0] sync;
  logic [CW-1:0] tick_cnt;
  logic tick;
  assign tick = tick_cnt == CW'(TICK_DIV - 1);
  assign rise = sync[1] & ~sync[2];
  assign fall = ~sync[1] & sync[2];
  // two synchroniser flops plus one history flop for edge detection
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) sync <= '0;
    else sync <= {sync[1:0], ir_in};
  // free-running carrier-period divider
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) tick_cnt <= '0;
    else tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
  // an edge restarts the count including the tick of that cycle, so N periods measure exactly N
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) width <= '0;
    else width <= (rise | fall) ? {7'b0, tick} : (tick && !(&width)) ? width + 8'd1 : width;
endmodule

// File: rtl/io_ir_rx.sv
// io_ir_rx: bus-mapped IR packet receiver decoding START/CARSEL/4 command bits with status and interrupt
module io_ir_rx
  import io_ir_rx_pkg::*;
#(
  parameter logic [7:0] RxBaseAddr  = IR_RX_ADDR,
  parameter int         TICK_DIV    = IR_FULL_PERIOD,
  parameter int         SZ_START    = int'(IR_BLUE.start),
  parameter int         SZ_CARSEL   = int'(IR_BLUE.carsel),
  parameter int         SZ_GAP      = int'(IR_BLUE.gap),
  parameter int         SZ_ASSERT   = int'(IR_BLUE.assert_w),
  parameter int         SZ_DEASSERT = int'(IR_BLUE.deassert_w),
  parameter int         TOL         = IR_TOL
) (
  input  logic       CLK,
  input  logic       RESET,
  inout  wire  [7:0] BUS_DATA,
  input  logic [7:0] BUS_ADDR,
  input  logic       BUS_WE,
  output logic       BUS_INTERRUPT_RAISE,
  input  logic       BUS_INTERRUPT_ACK,
  input  logic       IR_IN
);
  localparam int SZ_BIT_MAX = SZ_ASSERT > SZ_DEASSERT ? SZ_ASSERT : SZ_DEASSERT;
  ir_state_t st, nx;
  logic rise, fall, exp_edge, win_ok, ok_a, ok_d, err, adv, shift, acc;
  logic valid, ovr, rd_d, rd_s, wr_s;
  logic [7:0] width;
  logic [3:0] sh, data;
  logic [1:0] nbits;
  logic [5:0] errcnt;
  int lim;
  ir_pulse_meter #(.TICK_DIV(TICK_DIV)) u_meter (
    .CLK(CLK), .RESET(RESET), .ir_in(IR_IN), .rise(rise), .fall(fall), .width(width)
  );
  // state register
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) st <= S_IDLE;
    else st <= nx;
  // next state: errors always return to IDLE, accepted edges step through the packet
  always_comb begin
    nx = st;
    if (err) nx = S_IDLE;
    else if (adv)
      unique case (st)
        S_IDLE:   nx = S_START;
        S_START:  nx = S_GAP1;
        S_GAP1:   nx = S_CARSEL;
        S_CARSEL: nx = S_GAP2;
        S_GAP2:   nx = S_MARK;
        S_SPACE:  nx = S_MARK;
        S_MARK:   nx = acc ? S_IDLE : S_SPACE;
        default:  nx = S_IDLE;
      endcase
  end
  // per-state window check and timeout; marks end on a fall, spaces on a rise
  always_comb begin
    ok_a = in_win(width, SZ_ASSERT, TOL);
    ok_d = in_win(width, SZ_DEASSERT, TOL);
    exp_edge = (st == S_START || st == S_CARSEL || st == S_MARK) ? fall : rise;
    win_ok = st == S_START ? in_win(width, SZ_START, TOL) :
             st == S_CARSEL ? in_win(width, SZ_CARSEL, TOL) :
             st == S_MARK ? (ok_a | ok_d) :
             st == S_IDLE ? 1'b1 : in_win(width, SZ_GAP, TOL);
    lim = st == S_START ? SZ_START + TOL :
          st == S_CARSEL ? SZ_CARSEL + TOL :
          st == S_MARK ? SZ_BIT_MAX + TOL :
          st == S_IDLE ? 255 : SZ_GAP + TOL;
    err = st != S_IDLE && ((exp_edge && !win_ok) || int'(width) > lim);
    adv = exp_edge && !err;
    shift = adv && st == S_MARK;
    acc = shift && nbits == 2'd3;
  end
  // command shift register, cleared when a packet starts; first bit lands in CMD[3]
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      sh <= '0;
      nbits <= '0;
    end else if (adv && st == S_IDLE) begin
      sh <= '0;
      nbits <= '0;
    end else if (shift) begin
      sh <= {sh[2:0], ok_a};
      nbits <= nbits + 2'd1;
    end
  assign wr_s = BUS_WE && BUS_ADDR == RxBaseAddr + 8'd1;
  // register file: accept beats a same-cycle data read, status write clears the error count
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      data <= '0;
      valid <= 1'b0;
      ovr <= 1'b0;
      errcnt <= '0;
    end else begin
      if (acc) begin
        data <= {sh[2:0], ok_a};
        valid <= 1'b1;
        ovr <= ovr | valid;
      end else if (rd_d) begin
        valid <= 1'b0;
        ovr <= 1'b0;
      end
      errcnt <= wr_s ? '0 : (err && !(&errcnt)) ? errcnt + 6'd1 : errcnt;
    end
  // read strobes are registered so the bus is driven for exactly the following cycle
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      rd_d <= 1'b0;
      rd_s <= 1'b0;
      BUS_INTERRUPT_RAISE <= 1'b0;
    end else begin
      rd_d <= !BUS_WE && BUS_ADDR == RxBaseAddr;
      rd_s <= !BUS_WE && BUS_ADDR == RxBaseAddr + 8'd1;
      BUS_INTERRUPT_RAISE <= acc ? 1'b1 : BUS_INTERRUPT_ACK ? 1'b0 : BUS_INTERRUPT_RAISE;
    end
  assign BUS_DATA = rd_d ? {4'b0, data} : rd_s ? {valid, ovr, errcnt} : 8'bz;
endmodule

// File: tb/tb_io_ir_rx.sv
// tb_io_ir_rx: scoreboard bench for the IR receiver using a shortened carrier period
module tb_io_ir_rx;
  localparam int TD = 3;
  localparam logic [7:0] A_DAT = 8'h91;
  localparam logic [7:0] A_STA = 8'h92;
  typedef int seq_t [11];
  typedef struct packed {logic [3:0] idx; logic [7:0] w; logic [3:0] n; logic ok;} var_t;
  logic clk = 1'b0, rst_n, bus_we, ack, ir_in, raise, rd_q = 1'b0;
  logic [7:0] bus_addr, sb_e;
  wire [7:0] bus_data;
  logic [3:0] m_data;
  logic m_valid, m_ovr, m_raise;
  logic [5:0] m_err;
  logic [7:0] exp_q[$];
  string tag_q[$];
  string sb_t;
  int total = 0, bad = 0;
  var_t tbl [20] = '{
    '{4'd0, 8'd187, 4'd11, 1'b1}, '{4'd0, 8'd195, 4'd11, 1'b1}, '{4'd1, 8'd21, 4'd11, 1'b1},
    '{4'd1, 8'd29, 4'd11, 1'b1}, '{4'd2, 8'd43, 4'd11, 1'b1}, '{4'd2, 8'd51, 4'd11, 1'b1},
    '{4'd4, 8'd43, 4'd11, 1'b1}, '{4'd4, 8'd51, 4'd11, 1'b1}, '{4'd6, 8'd18, 4'd11, 1'b1},
    '{4'd6, 8'd26, 4'd11, 1'b1}, '{4'd0, 8'd186, 4'd1, 1'b0}, '{4'd0, 8'd196, 4'd1, 1'b0},
    '{4'd1, 8'd20, 4'd3, 1'b0}, '{4'd1, 8'd30, 4'd2, 1'b0}, '{4'd2, 8'd42, 4'd3, 1'b0},
    '{4'd2, 8'd52, 4'd3, 1'b0}, '{4'd4, 8'd42, 4'd5, 1'b0}, '{4'd4, 8'd52, 4'd5, 1'b0},
    '{4'd6, 8'd17, 4'd7, 1'b0}, '{4'd6, 8'd27, 4'd7, 1'b0}};
  for (genvar g = 0; g < 8; g++) pullup (bus_data[g]);
  io_ir_rx #(.TICK_DIV(TD)) dut (
    .CLK(clk), .RESET(rst_n), .BUS_DATA(bus_data), .BUS_ADDR(bus_addr), .BUS_WE(bus_we),
    .BUS_INTERRUPT_RAISE(raise), .BUS_INTERRUPT_ACK(ack), .IR_IN(ir_in)
  );
  always #5 clk = ~clk;
  always @(posedge clk) rd_q <= rst_n && !bus_we && (bus_addr == A_DAT || bus_addr == A_STA);
  always @(negedge clk)
    if (rd_q) begin
      if (exp_q.size() == 0) chk("sb_empty", 8'(exp_q.size()), 8'd1);
      else begin
        sb_e = exp_q.pop_front();
        sb_t = tag_q.pop_front();
        chk(sb_t, bus_data, sb_e);
      end
    end
  task automatic chk(input string t, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", t, got, exp);
    end
  endtask
  function automatic seq_t mk(input logic [3:0] c);
    seq_t s;
    s = '{191, 25, 47, 25, 0, 25, 0, 25, 0, 25, 0};
    for (int b = 0; b < 4; b++) s[4 + 2 * b] = c[3 - b] ? 47 : 22;
    return s;
  endfunction
  task automatic drive(input seq_t s, input int n, input bit tail, input bit ack_hit);
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      ir_in = (i % 2 == 0);
      repeat (s[i] * TD) @(negedge clk);
    end
    if (tail) begin
      ir_in = 1'b0;
      if (ack_hit) begin
        @(negedge clk);
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
      end
      repeat (60 * TD) @(negedge clk);
    end
  endtask
  task automatic pkt(input seq_t s, input logic [3:0] c, input bit ack_hit);
    drive(s, 11, 1'b1, ack_hit);
    m_ovr = m_ovr | m_valid;
    m_valid = 1'b1;
    m_data = c;
    m_raise = 1'b1;
    chk("raise_pkt", {7'b0, raise}, {7'b0, m_raise});
  endtask
  task automatic bad_pkt(input seq_t s, input int n);
    drive(s, n, 1'b1, 1'b0);
    m_err = (m_err == 6'd63) ? m_err : m_err + 6'd1;
    chk("raise_bad", {7'b0, raise}, {7'b0, m_raise});
  endtask
  task automatic rd(input logic [7:0] a, input string t);
    exp_q.push_back(a == A_DAT ? {4'b0, m_data} : {m_valid, m_ovr, m_err});
    tag_q.push_back(t);
    @(negedge clk);
    bus_addr = a;
    @(negedge clk);
    bus_addr = 8'h00;
    if (a == A_DAT) begin
      m_valid = 1'b0;
      m_ovr = 1'b0;
    end
    @(negedge clk);
    chk("bus_idle", bus_data, 8'hff);
  endtask
  task automatic ack_irq();
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    m_raise = 1'b0;
    @(negedge clk);
    chk("raise_ack", {7'b0, raise}, {7'b0, m_raise});
  endtask
  task automatic wr_stat();
    @(negedge clk);
    bus_addr = A_STA;
    bus_we = 1'b1;
    @(negedge clk);
    bus_addr = 8'h00;
    bus_we = 1'b0;
    m_err = '0;
  endtask
  task automatic model_reset();
    m_data = '0;
    m_valid = 1'b0;
    m_ovr = 1'b0;
    m_raise = 1'b0;
    m_err = '0;
  endtask
  initial begin
    seq_t s;
    rst_n = 1'b0;
    ir_in = 1'b0;
    bus_addr = 8'h00;
    bus_we = 1'b0;
    ack = 1'b0;
    model_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      ir_in = ~ir_in;
      if (i == 10) bus_addr = A_DAT;
    end
    @(negedge clk);
    chk("rst_raise", {7'b0, raise}, 8'h00);
    chk("rst_bus", bus_data, 8'hff);
    ir_in = 1'b0;
    bus_addr = 8'h00;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    rd(A_DAT, "rst_data");
    rd(A_STA, "rst_stat");
    pkt(mk(4'hA), 4'hA, 1'b0);
    rd(A_STA, "p1_stat");
    rd(A_DAT, "p1_data");
    rd(A_STA, "p1_stat_clr");
    ack_irq();
    s = mk(4'h5);
    s[0] = 150;
    bad_pkt(s, 1);
    rd(A_STA, "short_start_stat");
    pkt(mk(4'h5), 4'h5, 1'b0);
    rd(A_STA, "after_err_stat");
    rd(A_DAT, "after_err_data");
    ack_irq();
    wr_stat();
    rd(A_STA, "errclr_stat");
    pkt(mk(4'h3), 4'h3, 1'b0);
    pkt(mk(4'hC), 4'hC, 1'b0);
    rd(A_STA, "ovr_stat");
    rd(A_DAT, "ovr_data");
    rd(A_STA, "ovr_stat_clr");
    ack_irq();
    bad_pkt(mk(4'hA), 7);
    rd(A_STA, "cut_stat");
    pkt(mk(4'h9), 4'h9, 1'b0);
    drive(mk(4'h6), 5, 1'b0, 1'b0);
    rst_n = 1'b0;
    model_reset();
    repeat (5) @(negedge clk);
    ir_in = 1'b0;
    chk("midrst_raise", {7'b0, raise}, {7'b0, m_raise});
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    rd(A_STA, "midrst_stat");
    rd(A_DAT, "midrst_data");
    for (int i = 0; i < 20; i++) begin
      s = mk(4'hA);
      s[tbl[i].idx] = int'(tbl[i].w);
      if (tbl[i].ok) begin
        pkt(s, 4'hA, 1'b0);
        rd(A_STA, "edge_ok_stat");
        rd(A_DAT, "edge_ok_data");
        ack_irq();
      end else begin
        bad_pkt(s, int'(tbl[i].n));
        rd(A_STA, "edge_bad_stat");
      end
    end
    wr_stat();
    pkt(mk(4'h6), 4'h6, 1'b1);
    rd(A_STA, "ackhit_stat");
    rd(A_DAT, "ackhit_data");
    ack_irq();
    repeat (4) @(negedge clk);
    chk("sb_left", 8'(exp_q.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
